// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states (ISSUE, WAIT, KILL, HOLD)
//   NOP_FLUSH     : word presented to IF/ID when the instruction is flushed
//   STALL_CNT_MAX : saturation value of the stall-cycle counter
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,  // launch a request at the current PC
    WAIT  = 2'd1,  // request outstanding, response still wanted
    KILL  = 2'd2,  // request outstanding, response is stale and dropped
    HOLD  = 2'd3   // response captured while ID is stalled
  } fetch_state_t;

  localparam logic [31:0] NOP_FLUSH     = 32'h0000_0000;
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that stops at MAX instead of wrapping.
//   clk   in  clock
//   rst   in  asynchronous active-high reset, clears the count
//   en    in  count this cycle
//   count out current value
module sat_counter #(
  parameter int          W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (en && (count_reg != MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch sequencer: drives a single-outstanding-request
//   instruction-memory handshake and the IF-stage pipeline controls,
//   resolving EX redirects and ID load-use stalls against variable latency.
//   clk, rst          clock, asynchronous active-high reset
//   branch_taken      EX redirect this cycle
//   hazard_stall      load-use stall, ID must hold
//   im_req            one-cycle fetch request at the current IF PC
//   im_ready/im_rdata fetch response and its instruction word
//   instr_out         instruction presented to IF/ID
//   PC_write          PC load enable
//   IFID_RegWrite     IF/ID write enable
//   InstrFlush        IF/ID loads a bubble
//   IDEX_flush        ID/EX bubble
//   stall_cycles      saturating count of cycles with no fresh instruction
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic            hazard_stall,
  output logic            im_req,
  input  logic            im_ready,
  input  logic [XLEN-1:0] im_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic            PC_write,
  output logic            IFID_RegWrite,
  output logic            InstrFlush,
  output logic            IDEX_flush,
  output logic [31:0]     stall_cycles
);

  fetch_state_t    state_reg;
  fetch_state_t    state_next;
  logic [XLEN-1:0] hold_reg;
  logic [XLEN-1:0] hold_next;

  // Raw decode of state and inputs; gated by rst at the outputs.
  logic req_raw;
  logic pc_write_raw;
  logic ifid_write_raw;
  logic flush_raw;
  logic sel_rdata;
  logic sel_hold;
  logic capture;

  always_comb begin
    state_next     = state_reg;
    req_raw        = 1'b0;
    pc_write_raw   = 1'b0;
    ifid_write_raw = 1'b0;
    flush_raw      = 1'b1;
    sel_rdata      = 1'b0;
    sel_hold       = 1'b0;
    capture        = 1'b0;

    unique case (state_reg)
      ISSUE: begin
        // A redirect here means the current PC is already wrong, so the
        // request is skipped and the new PC gets its own ISSUE cycle.
        if (branch_taken) begin
          pc_write_raw   = 1'b1;
          ifid_write_raw = 1'b1;
        end else begin
          req_raw        = 1'b1;
          ifid_write_raw = !hazard_stall;
          state_next     = WAIT;
        end
      end

      WAIT: begin
        if (!im_ready) begin
          if (branch_taken) begin
            // The response still has to come back; KILL swallows it.
            pc_write_raw   = 1'b1;
            ifid_write_raw = 1'b1;
            state_next     = KILL;
          end else begin
            ifid_write_raw = !hazard_stall;
          end
        end else if (branch_taken) begin
          pc_write_raw   = 1'b1;
          ifid_write_raw = 1'b1;
          state_next     = ISSUE;
        end else if (hazard_stall) begin
          // ID cannot accept the word yet: park it and keep the PC.
          capture    = 1'b1;
          sel_rdata  = 1'b1;
          flush_raw  = 1'b0;
          state_next = HOLD;
        end else begin
          sel_rdata      = 1'b1;
          pc_write_raw   = 1'b1;
          ifid_write_raw = 1'b1;
          flush_raw      = 1'b0;
          state_next     = ISSUE;
        end
      end

      KILL: begin
        ifid_write_raw = 1'b1;
        pc_write_raw   = branch_taken;
        if (im_ready) begin
          state_next = ISSUE;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_write_raw   = 1'b1;
          ifid_write_raw = 1'b1;
          state_next     = ISSUE;
        end else if (hazard_stall) begin
          sel_hold  = 1'b1;
          flush_raw = 1'b0;
        end else begin
          sel_hold       = 1'b1;
          pc_write_raw   = 1'b1;
          ifid_write_raw = 1'b1;
          flush_raw      = 1'b0;
          state_next     = ISSUE;
        end
      end

      default: begin
        state_next = ISSUE;
      end
    endcase
  end

  assign hold_next = capture ? im_rdata : hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ISSUE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Reset forces every output low, even though the state decodes ISSUE.
  assign im_req        = !rst && req_raw;
  assign PC_write      = !rst && pc_write_raw;
  assign IFID_RegWrite = !rst && ifid_write_raw;
  assign InstrFlush    = !rst && flush_raw;
  assign IDEX_flush    = !rst && (branch_taken || hazard_stall);

  always_comb begin
    instr_out = XLEN'(NOP_FLUSH);
    if (!rst && !flush_raw) begin
      if (sel_hold) begin
        instr_out = hold_reg;
      end else if (sel_rdata) begin
        instr_out = im_rdata;
      end
    end
  end

  logic stall_en;
  assign stall_en = !rst && (!ifid_write_raw || flush_raw);

  sat_counter #(
    .W   (32),
    .MAX (STALL_CNT_MAX)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en),
    .count (stall_cycles)
  );

`ifndef SYNTHESIS
  // A response with no request outstanding breaks the memory handshake.
  a_no_ready_in_issue : assert property (
    @(posedge clk) disable iff (rst) !((state_reg == ISSUE) && im_ready)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. Each task resets the DUT, plays one
//   scenario cycle by cycle and compares outputs against hand-derived values.
//   Control outputs are compared as one vector:
//   {im_req, PC_write, IFID_RegWrite, InstrFlush, IDEX_flush}.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic        hazard_stall;
  logic        im_req;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] instr_out;
  logic        PC_write;
  logic        IFID_RegWrite;
  logic        InstrFlush;
  logic        IDEX_flush;
  logic [31:0] stall_cycles;
  logic [4:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .hazard_stall  (hazard_stall),
    .im_req        (im_req),
    .im_ready      (im_ready),
    .im_rdata      (im_rdata),
    .instr_out     (instr_out),
    .PC_write      (PC_write),
    .IFID_RegWrite (IFID_RegWrite),
    .InstrFlush    (InstrFlush),
    .IDEX_flush    (IDEX_flush),
    .stall_cycles  (stall_cycles)
  );

  assign ctl = {im_req, PC_write, IFID_RegWrite, InstrFlush, IDEX_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench in the first cycle after reset release, inputs idle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; branch_taken = 1'b0; hazard_stall = 1'b0;
    im_ready = 1'b0; im_rdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    branch_taken = 1'b1; hazard_stall = 1'b1;
    im_ready = 1'b0; im_rdata = 32'hA5A5_5A5A;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (ctl !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00000);
    end
    n_checks++;
    if (instr_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_out, 32'h0);
    end
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
    end
    $display("reset: ctl=%b instr=%h stall=%0d", ctl, instr_out, stall_cycles);
  endtask

  task automatic test_latency1();
    do_reset();
    n_checks++;
    if (ctl !== 5'b10110) begin
      n_fail++; $display("FAIL lat1_issue: got %b expected %b", ctl, 5'b10110);
    end
    nxt(); im_ready = 1'b1; im_rdata = 32'h0050_0093; #1;
    n_checks++;
    if (ctl !== 5'b01100) begin
      n_fail++; $display("FAIL lat1_deliver_ctl: got %b expected %b", ctl, 5'b01100);
    end
    n_checks++;
    if (instr_out !== 32'h0050_0093) begin
      n_fail++; $display("FAIL lat1_deliver_instr: got %h expected %h", instr_out, 32'h0050_0093);
    end
    nxt(); im_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b10110) begin
      n_fail++; $display("FAIL lat1_next_req: got %b expected %b", ctl, 5'b10110);
    end
    n_checks++;
    if (stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL lat1_stall: got %0d expected 1", stall_cycles);
    end
    $display("latency1: instr=00500093 delivered, stall=%0d", stall_cycles);
  endtask

  task automatic test_latency3();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      nxt(); #1;
      n_checks++;
      if (ctl !== 5'b00110) begin
        n_fail++; $display("FAIL lat3_wait%0d: got %b expected %b", i, ctl, 5'b00110);
      end
    end
    nxt(); im_ready = 1'b1; im_rdata = 32'h00A0_0113; #1;
    n_checks++;
    if (instr_out !== 32'h00A0_0113 || ctl !== 5'b01100) begin
      n_fail++; $display("FAIL lat3_deliver: got %h/%b expected %h/%b",
                         instr_out, ctl, 32'h00A0_0113, 5'b01100);
    end
    nxt(); im_ready = 1'b0; #1;
    n_checks++;
    if (stall_cycles !== 32'd3) begin
      n_fail++; $display("FAIL lat3_stall: got %0d expected 3", stall_cycles);
    end
    $display("latency3: delivered after 2 wait cycles, stall=%0d", stall_cycles);
  endtask

  task automatic test_branch_kill();
    do_reset();
    nxt(); branch_taken = 1'b1; #1;
    n_checks++;
    if (ctl !== 5'b01111) begin
      n_fail++; $display("FAIL kill_redirect: got %b expected %b", ctl, 5'b01111);
    end
    nxt(); branch_taken = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b00110) begin
      n_fail++; $display("FAIL kill_idle: got %b expected %b", ctl, 5'b00110);
    end
    nxt(); im_ready = 1'b1; im_rdata = 32'hDEAD_BEEF; #1;
    n_checks++;
    if (ctl !== 5'b00110 || instr_out !== 32'h0) begin
      n_fail++; $display("FAIL kill_drop: got %b/%h expected %b/%h",
                         ctl, instr_out, 5'b00110, 32'h0);
    end
    nxt(); im_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b10110) begin
      n_fail++; $display("FAIL kill_reissue: got %b expected %b", ctl, 5'b10110);
    end
    $display("branch_kill: stale DEADBEEF dropped, reissue ctl=%b", ctl);
  endtask

  task automatic test_kill_redirect();
    do_reset();
    nxt(); branch_taken = 1'b1; #1;
    nxt(); #1;
    n_checks++;
    if (ctl !== 5'b01111) begin
      n_fail++; $display("FAIL kill_rebranch: got %b expected %b", ctl, 5'b01111);
    end
    nxt(); branch_taken = 1'b0; im_ready = 1'b1; im_rdata = 32'h1111_2222; #1;
    n_checks++;
    if (ctl !== 5'b00110 || instr_out !== 32'h0) begin
      n_fail++; $display("FAIL kill_rebranch_drop: got %b/%h expected %b/%h",
                         ctl, instr_out, 5'b00110, 32'h0);
    end
    nxt(); im_ready = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b10110) begin
      n_fail++; $display("FAIL kill_rebranch_issue: got %b expected %b", ctl, 5'b10110);
    end
    $display("kill_redirect: repeated redirect reloads PC, ctl=%b", ctl);
  endtask

  task automatic test_hazard_hold();
    do_reset();
    nxt(); im_ready = 1'b1; hazard_stall = 1'b1; im_rdata = 32'h1234_5678; #1;
    n_checks++;
    if ({PC_write, IFID_RegWrite, IDEX_flush} !== 3'b001) begin
      n_fail++; $display("FAIL hold_capture: got %b expected %b",
                         {PC_write, IFID_RegWrite, IDEX_flush}, 3'b001);
    end
    nxt(); im_ready = 1'b0; im_rdata = 32'h0; #1;
    n_checks++;
    if (ctl !== 5'b00001 || instr_out !== 32'h1234_5678) begin
      n_fail++; $display("FAIL hold_stall: got %b/%h expected %b/%h",
                         ctl, instr_out, 5'b00001, 32'h1234_5678);
    end
    nxt(); hazard_stall = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b01100 || instr_out !== 32'h1234_5678) begin
      n_fail++; $display("FAIL hold_release: got %b/%h expected %b/%h",
                         ctl, instr_out, 5'b01100, 32'h1234_5678);
    end
    nxt(); #1;
    n_checks++;
    if (ctl !== 5'b10110 || stall_cycles !== 32'd3) begin
      n_fail++; $display("FAIL hold_after: got %b/%0d expected %b/3",
                         ctl, stall_cycles, 5'b10110);
    end
    $display("hazard_hold: held 12345678 for 2 cycles, stall=%0d", stall_cycles);
  endtask

  task automatic test_hold_branch();
    do_reset();
    nxt(); im_ready = 1'b1; hazard_stall = 1'b1; im_rdata = 32'hCAFE_F00D; #1;
    nxt(); im_ready = 1'b0; branch_taken = 1'b1; #1;
    n_checks++;
    if (ctl !== 5'b01111 || instr_out !== 32'h0) begin
      n_fail++; $display("FAIL hold_branch: got %b/%h expected %b/%h",
                         ctl, instr_out, 5'b01111, 32'h0);
    end
    nxt(); branch_taken = 1'b0; hazard_stall = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b10110) begin
      n_fail++; $display("FAIL hold_branch_issue: got %b expected %b", ctl, 5'b10110);
    end
    $display("hold_branch: redirect wins over stall, ctl=%b", ctl);
  endtask

  task automatic test_issue_cases();
    do_reset();
    hazard_stall = 1'b1; #1;
    n_checks++;
    if (ctl !== 5'b10011) begin
      n_fail++; $display("FAIL issue_hazard: got %b expected %b", ctl, 5'b10011);
    end
    nxt(); #1;
    n_checks++;
    if (ctl !== 5'b00011) begin
      n_fail++; $display("FAIL wait_hazard: got %b expected %b", ctl, 5'b00011);
    end
    nxt(); hazard_stall = 1'b0; im_ready = 1'b1; im_rdata = 32'h0000_0013; #1;
    nxt(); im_ready = 1'b0; branch_taken = 1'b1; #1;
    n_checks++;
    if (ctl !== 5'b01111) begin
      n_fail++; $display("FAIL issue_branch: got %b expected %b", ctl, 5'b01111);
    end
    nxt(); branch_taken = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b10110) begin
      n_fail++; $display("FAIL issue_branch_stay: got %b expected %b", ctl, 5'b10110);
    end
    $display("issue_cases: hazard and redirect in ISSUE, ctl=%b", ctl);
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    nxt(); #1;
    n_checks++;
    if (ctl !== 5'b00110 || stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL midwait_pre: got %b/%0d expected %b/1",
                         ctl, stall_cycles, 5'b00110);
    end
    rst = 1'b1; branch_taken = 1'b1; #1;
    n_checks++;
    if (ctl !== 5'b00000 || instr_out !== 32'h0 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL midwait_rst: got %b/%h/%0d expected 00000/00000000/0",
                         ctl, instr_out, stall_cycles);
    end
    nxt(); branch_taken = 1'b0;
    nxt(); rst = 1'b0; #1;
    n_checks++;
    if (ctl !== 5'b10110 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL midwait_restart: got %b/%0d expected %b/0",
                         ctl, stall_cycles, 5'b10110);
    end
    nxt(); im_ready = 1'b1; im_rdata = 32'h0010_0073; #1;
    n_checks++;
    if (instr_out !== 32'h0010_0073) begin
      n_fail++; $display("FAIL midwait_deliver: got %h expected %h", instr_out, 32'h0010_0073);
    end
    nxt(); im_ready = 1'b0; #1;
    n_checks++;
    if (stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL midwait_stall: got %0d expected 1", stall_cycles);
    end
    $display("reset_mid_wait: outputs cleared, restart stall=%0d", stall_cycles);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h0010_0093;
    words[1] = 32'h0020_0113;
    words[2] = 32'h0030_0193;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ctl !== 5'b10110) begin
        n_fail++; $display("FAIL b2b_issue%0d: got %b expected %b", i, ctl, 5'b10110);
      end
      nxt(); im_ready = 1'b1; im_rdata = words[i]; #1;
      n_checks++;
      if (instr_out !== words[i] || ctl !== 5'b01100) begin
        n_fail++; $display("FAIL b2b_deliver%0d: got %h/%b expected %h/%b",
                           i, instr_out, ctl, words[i], 5'b01100);
      end
      nxt(); im_ready = 1'b0; #1;
    end
    n_checks++;
    if (stall_cycles !== 32'd3) begin
      n_fail++; $display("FAIL b2b_stall: got %0d expected 3", stall_cycles);
    end
    $display("back_to_back: 3 instructions in 6 cycles, stall=%0d", stall_cycles);
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0; hazard_stall = 1'b0;
    im_ready = 1'b0; im_rdata = 32'h0;
    test_reset();
    test_latency1();
    test_latency3();
    test_branch_kill();
    test_kill_redirect();
    test_hazard_hold();
    test_hold_branch();
    test_issue_cases();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
